// File: rtl/apb_master_bridge_if.sv
// Signal bundle between the command/response client, the bridge and the
// APB slave side. The master modport is the bridge's view; the slave
// modport is the view of whatever drives commands and answers APB.
interface apb_master_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AW-1:0]     cmd_addr;
    logic [DW-1:0]     cmd_wdata;
    logic [DW/8-1:0]   cmd_strb;
    // response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    // APB bus
    logic [AW-1:0]     PADDR;
    logic [1:0]        PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DW-1:0]     PWDATA;
    logic [DW/8-1:0]   PSTRB;
    logic [2:0]        PPROT;
    logic              PREADY;
    logic [DW-1:0]     PRDATA;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding command-to-APB bridge. A command is accepted in IDLE,
// driven as an APB SETUP/ACCESS pair to one of two slaves (chosen by one
// address bit), and its result is held in RESP until the client takes it.
// A slave that never raises PREADY is abandoned after TIMEOUT ACCESS cycles
// and reported as an error. Every output comes straight from a flop.
module apb_master_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SEL_BIT = 12,
    parameter int TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_master_bridge_if.master  bus
);

    localparam int SW = DW / 8;
    localparam int CW = $clog2(TIMEOUT + 1);
    // Wait-counter value seen in the last ACCESS cycle before giving up.
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t          state_q,     state_d;
    logic [CW-1:0]   wait_cnt_q,  wait_cnt_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic [AW-1:0]   paddr_q,     paddr_d;
    logic [1:0]      psel_q,      psel_d;
    logic            penable_q,   penable_d;
    logic            pwrite_q,    pwrite_d;
    logic [DW-1:0]   pwdata_q,    pwdata_d;
    logic [SW-1:0]   pstrb_q,     pstrb_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q,   rsp_err_d;

    // Next-state and next-output decode; every register holds unless its
    // state says otherwise.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        cmd_ready_d = cmd_ready_q;
        paddr_d     = paddr_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready is a flop, so it rises on the first edge after
                // reset release and stays up while idle.
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d     = ST_SETUP;
                    cmd_ready_d = 1'b0;
                    paddr_d     = bus.cmd_addr;
                    pwrite_d    = bus.cmd_write;
                    penable_d   = 1'b0;
                    psel_d      = bus.cmd_addr[SEL_BIT] ? 2'b10 : 2'b01;
                    if (bus.cmd_write) begin
                        pwdata_d = bus.cmd_wdata;
                        pstrb_d  = bus.cmd_strb;
                    end else begin
                        // Reads leave PWDATA untouched and drive no strobes.
                        pwdata_d = pwdata_q;
                        pstrb_d  = {SW{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SETUP: begin
                state_d    = ST_ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = {CW{1'b0}};
            end

            ST_ACCESS: begin
                if (bus.PREADY) begin
                    state_d     = ST_RESP;
                    psel_d      = 2'b00;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.PSLVERR;
                    rsp_rdata_d = pwrite_q ? {DW{1'b0}} : bus.PRDATA;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Slave never answered: drop the bus and report an error.
                    state_d     = ST_RESP;
                    psel_d      = 2'b00;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = {DW{1'b0}};
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b0;
                psel_d      = 2'b00;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= {CW{1'b0}};
            cmd_ready_q <= 1'b0;
            paddr_q     <= {AW{1'b0}};
            psel_q      <= 2'b00;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= {DW{1'b0}};
            pstrb_q     <= {SW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DW{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.PPROT     = 3'b000;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios plus random traffic.
// Expected responses come from a transaction-level model and are queued at
// command acceptance; a monitor pops them when the response is taken.
module tb_apb_master_bridge;

    localparam int TIMEOUT = 16;

    logic PCLK = 1'b0;
    logic PRESETn;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    apb_master_bridge_if #(.AW(32), .DW(32)) bus ();

    apb_master_bridge #(.AW(32), .DW(32), .SEL_BIT(12), .TIMEOUT(TIMEOUT)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    // current transfer as seen by the slave model and bus checker
    int          cur_wait = 0;
    logic [31:0] cur_prdata = 32'h0;
    logic        cur_err = 1'b0;
    logic [31:0] act_addr = 32'h0;
    logic        act_write = 1'b0;
    logic [3:0]  act_strb = 4'h0;
    logic [1:0]  act_psel = 2'b00;
    logic [31:0] act_pwdata = 32'h0;
    logic [31:0] last_wdata = 32'h0;
    int          rr_mode = 0;   // 0 random, 1 hold low, 2 hold high

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Issue one command; returns at the negedge after acceptance.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int w, input logic [31:0] prd,
                         input logic err);
        int   n;
        int   a;
        bit   done;
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.cmd_strb  = st;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (bus.cmd_ready === 1'b1) begin
                n = cyc;
                @(posedge PCLK);
                done = 1'b1;
                a = (w >= TIMEOUT) ? TIMEOUT : w + 1;
                e.acc   = a;
                e.due   = n + 2 + a;
                e.err   = (w >= TIMEOUT) ? 1'b1 : err;
                e.rdata = (w >= TIMEOUT || wr) ? 32'h0 : prd;
                exp_q.push_back(e);
                cur_wait   = w;
                cur_prdata = prd;
                cur_err    = err;
                act_addr   = addr;
                act_write  = wr;
                act_strb   = wr ? st : 4'h0;
                act_psel   = addr[12] ? 2'b10 : 2'b01;
                act_pwdata = wr ? wd : last_wdata;
                if (wr) last_wdata = wd;
            end
            @(negedge PCLK);
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL issue_accept: got no acceptance expected cmd_ready within 400 cycles");
        end
    endtask

    // Wait until every queued response has been taken and the bridge is idle.
    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge PCLK);
            if (exp_q.size() == 0 && bus.cmd_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0 within 1000 cycles", exp_q.size());
        end
    endtask

    // APB slave model: waits cur_wait ACCESS cycles, junk outside ACCESS.
    initial begin
        int  acc_cnt;
        bit  rdy;
        acc_cnt = 0;
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h0;
        bus.PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            if (bus.PSEL != 2'b00 && bus.PENABLE) begin
                rdy = (acc_cnt >= cur_wait);
                bus.PREADY  = rdy;
                bus.PRDATA  = rdy ? cur_prdata : $urandom;
                bus.PSLVERR = rdy ? cur_err : 1'($urandom % 2);
                acc_cnt++;
            end else begin
                acc_cnt = 0;
                bus.PREADY  = 1'($urandom % 2);
                bus.PRDATA  = $urandom;
                bus.PSLVERR = 1'($urandom % 2);
            end
        end
    end

    // Response consumer.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge PCLK);
            case (rr_mode)
                0:       bus.rsp_ready = (($urandom % 4) != 0);
                1:       bus.rsp_ready = 1'b0;
                default: bus.rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: bus legality, latency, response stability and scoreboard.
    initial begin
        bit          outstanding;
        bit          prev_hold;
        logic        prev_rv;
        logic [31:0] prev_rdata;
        logic        prev_err;
        int          setup_n;
        int          acc_n;
        exp_t        e;
        outstanding = 0; prev_hold = 0; prev_rv = 0; prev_rdata = 0; prev_err = 0;
        setup_n = 0; acc_n = 0;
        forever begin
            @(negedge PCLK);
            #1;
            if (!PRESETn) begin
                outstanding = 0; prev_hold = 0; prev_rv = 0; setup_n = 0; acc_n = 0;
            end else begin
                if (bus.PENABLE) check("penable_needs_psel", 64'(bus.PSEL != 2'b00), 64'd1);
                if (bus.PSEL != 2'b00) begin
                    check("psel", 64'(bus.PSEL), 64'(act_psel));
                    check("paddr", 64'(bus.PADDR), 64'(act_addr));
                    check("pwrite", 64'(bus.PWRITE), 64'(act_write));
                    check("pstrb", 64'(bus.PSTRB), 64'(act_strb));
                    check("pwdata", 64'(bus.PWDATA), 64'(act_pwdata));
                    check("pprot", 64'(bus.PPROT), 64'd0);
                    if (bus.PENABLE) acc_n++;
                    else setup_n++;
                end
                if (prev_hold) begin
                    check("rsp_hold_valid", 64'(bus.rsp_valid), 64'd1);
                    check("rsp_hold_rdata", 64'(bus.rsp_rdata), 64'(prev_rdata));
                    check("rsp_hold_err", 64'(bus.rsp_err), 64'(prev_err));
                end
                if (bus.rsp_valid) check("cmd_ready_in_resp", 64'(bus.cmd_ready), 64'd0);
                if (bus.rsp_valid && !prev_rv) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
                    end else begin
                        check("rsp_latency", 64'(cyc), 64'(exp_q[0].due));
                        check("access_cycles", 64'(acc_n), 64'(exp_q[0].acc));
                        check("setup_cycles", 64'(setup_n), 64'd1);
                    end
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_pop_empty", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                        check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    end
                    outstanding = 0;
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    check("one_outstanding", 64'(outstanding), 64'd0);
                    outstanding = 1;
                    setup_n = 0;
                    acc_n = 0;
                end
                prev_hold  = bus.rsp_valid && !bus.rsp_ready;
                prev_rv    = bus.rsp_valid;
                prev_rdata = bus.rsp_rdata;
                prev_err   = bus.rsp_err;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before 400000");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"},    64'(bus.PSEL), 64'd0);
        check({tag, "_penable"}, 64'(bus.PENABLE), 64'd0);
        check({tag, "_pwrite"},  64'(bus.PWRITE), 64'd0);
        check({tag, "_paddr"},   64'(bus.PADDR), 64'd0);
        check({tag, "_pwdata"},  64'(bus.PWDATA), 64'd0);
        check({tag, "_pstrb"},   64'(bus.PSTRB), 64'd0);
        check({tag, "_rsp"},     64'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}), 64'd0);
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
    endtask

    // Main stimulus.
    initial begin
        logic        wr;
        logic [31:0] addr;
        int          w;
        bit          seen;
        PRESETn = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.cmd_strb  = 4'h0;
        repeat (3) @(negedge PCLK);
        #1;
        check_reset_outputs("por");
        #2 PRESETn = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        check("cmd_ready_after_por", 64'(bus.cmd_ready), 64'd1);

        // zero-wait write to slave 0
        rr_mode = 2;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
        drain();

        // read from slave 1 with three wait states
        issue(1'b0, 32'h0000_1004, 32'h5555_5555, 4'hA, 3, 32'h1234_5678, 1'b0);
        drain();

        // slave error on a write, response held off for 5 cycles while the
        // next command waits
        rr_mode = 1;
        issue(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3, 0, 32'h0, 1'b1);
        fork
            issue(1'b0, 32'h0000_1100, 32'h0, 4'hF, 1, 32'hA5A5_0F0F, 1'b0);
            begin
                seen = 1'b0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge PCLK);
                    if (bus.rsp_valid === 1'b1) seen = 1'b1;
                end
                check("hold_rsp_seen", 64'(seen), 64'd1);
                repeat (5) @(negedge PCLK);
                rr_mode = 2;
            end
        join
        drain();

        // stuck slave, and both sides of the timeout boundary
        rr_mode = 0;
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 40, 32'hFFFF_FFFF, 1'b0);
        issue(1'b0, 32'h0000_1048, 32'h0, 4'h0, 15, 32'h0BAD_CAFE, 1'b0);
        issue(1'b1, 32'h0000_0050, 32'h1111_2222, 4'h6, 16, 32'h0, 1'b0);
        drain();

        // random traffic
        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom % 2);
            addr = $urandom;
            w    = (($urandom % 8) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
            issue(wr, addr, $urandom, 4'($urandom), w, $urandom, 1'($urandom % 2));
        end
        drain();

        // reset in the middle of ACCESS
        rr_mode = 2;
        issue(1'b1, 32'h0000_1200, 32'h7777_8888, 4'hF, 10, 32'h0, 1'b0);
        @(negedge PCLK);
        check("abort_in_access", 64'(bus.PENABLE), 64'd1);
        #3 PRESETn = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        last_wdata = 32'h0;
        repeat (2) @(negedge PCLK);
        check("cmd_ready_in_reset", 64'(bus.cmd_ready), 64'd0);
        #3 PRESETn = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        check("cmd_ready_after_abort", 64'(bus.cmd_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        check("no_rsp_after_abort", 64'(seen), 64'd0);

        // bridge still works after the abort
        issue(1'b0, 32'h0000_0060, 32'h0, 4'h0, 2, 32'h2468_ACE0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameters SHALL be:
- AW, 32, address width.
- DW, 32, data width.
- SEL_BIT, 12, address bit that selects the slave.
- TIMEOUT, 16, maximum ACCESS cycles to wait for PREADY.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- PCLK, in, 1, sole clock.
- PRESETn, in, 1, reset; asynchronous, active-low.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, command accepted.
- cmd_write, in, 1, 1 = write, 0 = read.
- cmd_addr, in, AW, target address.
- cmd_wdata, in, DW, write data.
- cmd_strb, in, DW/8, write byte strobes.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, response consumed.
- rsp_rdata, out, DW, read data.
- rsp_err, out, 1, PSLVERR or timeout.
- PADDR, out, AW, APB address.
- PSEL, out, 2, one-hot slave select.
- PENABLE, out, 1, APB enable.
- PWRITE, out, 1, APB direction.
- PWDATA, out, DW, APB write data.
- PSTRB, out, DW/8, APB strobes.
- PPROT, out, 3, protection; constant 3'b000.
- PREADY, in, 1, muxed slave ready.
- PRDATA, in, DW, muxed slave read data.
- PSLVERR, in, 1, muxed slave error.

Function
REQ-003 The block SHALL implement the FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE, with all outputs registered.
REQ-004 cmd_ready SHALL be 1 only in IDLE. A command is accepted on a cycle with cmd_valid && cmd_ready, and the FSM moves to SETUP on the next edge.
REQ-005 On acceptance the block SHALL latch addr, write, wdata and strb. PADDR, PWRITE, PWDATA and PSTRB SHALL hold these values from SETUP through the end of ACCESS.
REQ-006 For a read, PSTRB SHALL be all zeros and PWDATA SHALL hold its previous value.
REQ-007 SETUP SHALL last exactly one cycle with PSEL one-hot and PENABLE=0:
- PSEL=2'b01 when cmd_addr[SEL_BIT]=0.
- PSEL=2'b10 when cmd_addr[SEL_BIT]=1.
REQ-008 In ACCESS, PENABLE SHALL be 1 and PSEL SHALL be unchanged.
REQ-009 ACCESS SHALL complete on the first rising edge where PREADY=1. On that edge the block SHALL:
- capture PRDATA (reads only) and PSLVERR;
- clear PSEL and PENABLE;
- enter RESP.
REQ-010 While PREADY=0, ACCESS SHALL hold and a wait counter SHALL increment.
REQ-011 If the counter reaches TIMEOUT with PREADY still 0, the block SHALL:
- terminate the transfer (PSEL and PENABLE cleared on that edge);
- enter RESP with rsp_err=1 and rsp_rdata=0.
REQ-012 PREADY and PSLVERR SHALL be ignored outside ACCESS.
REQ-013 Minimum latency SHALL be: acceptance at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid=1 at N+3 when PREADY=1 in the first ACCESS cycle.
REQ-014 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be held stable until rsp_valid && rsp_ready. After that handshake the FSM returns to IDLE.
REQ-015 rsp_rdata SHALL be 0 for writes, and rsp_err SHALL equal the captured PSLVERR for writes.
REQ-016 rsp_ready asserted while rsp_valid=0 SHALL have no effect.
REQ-017 Only one transfer SHALL be outstanding at a time. A new command is not accepted until the cycle after the response handshake, when the FSM is back in IDLE.
REQ-018 PSEL SHALL never have both bits set. PENABLE SHALL never be 1 while PSEL=0.

Reset
REQ-019 PRESETn low SHALL asynchronously force:
- FSM to IDLE and wait counter to 0;
- PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0;
- rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-020 cmd_ready SHALL be 0 while PRESETn is low and SHALL be 1 in the first cycle after release.
REQ-021 Reset asserted mid-transfer (SETUP, ACCESS or RESP) SHALL abort the transfer with no response issued.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write addr 0x0000_0010, data 0xDEADBEEF, strb 4'hF, PREADY tied 1 -> PSEL=01 for 2 cycles (PENABLE 0 then 1); rsp_valid at N+3 with rsp_err=0.
- Read addr 0x0000_1004, PREADY low for 3 ACCESS cycles, PRDATA=0x12345678 -> PSEL=10; ACCESS lasts 4 cycles; rsp_rdata=0x12345678; PSTRB=0 throughout.
- Write with PSLVERR=1 coincident with PREADY=1 -> rsp_err=1; next command accepted only after rsp_ready.
- PREADY stuck 0 -> after 16 ACCESS cycles PSEL and PENABLE drop; rsp_err=1 and rsp_rdata=0.
- rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable; cmd_ready stays 0.
- PRESETn pulsed low during ACCESS -> all outputs at reset values immediately; no rsp_valid; cmd_ready=1 after release.
